// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared types and default sizes for the counter controller
//
// Contents:
//   DEFAULT_WIDTH - default counter width in bits
//   DEFAULT_TICKW - default terminal-count tally width in bits
//   state_t       - controller state: IDLE, RUN, PAUSE, DONE
package counter_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 17;
    localparam int DEFAULT_TICKW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_core.sv
// rtl/counter_core.sv - plain WIDTH-bit up-counter with clear and enable
//
// Ports:
//   clk     - clock, rising edge
//   reset   - asynchronous active-low reset, forces count to 0
//   i_clr   - synchronous clear (wins over i_en)
//   i_en    - increment by one this cycle
//   o_count - current count
module counter_core
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - configurable one-shot/periodic counter with start/pause/stop sequencing
//
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   cfg_valid    - configuration word offered
//   cfg_ready    - configuration accepted this cycle (only in IDLE)
//   cfg_limit    - terminal count value
//   cfg_periodic - 1 = auto-restart at terminal count, 0 = one-shot
//   start        - start from IDLE/DONE, resume from PAUSE
//   pause        - freeze counting (from RUN)
//   stop         - return to IDLE with count cleared
//   count        - current counter value
//   tick         - terminal count reached this cycle
//   busy         - RUN or PAUSE
//   done         - one-shot run finished
//   ticks        - saturating number of terminal counts since last start
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int TICKW = DEFAULT_TICKW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_periodic,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [TICKW-1:0] ticks
);

    state_t           r_state;
    logic [WIDTH-1:0] r_limit;
    logic             r_periodic;
    logic [TICKW-1:0] r_ticks;

    state_t           w_next_state;
    logic             w_cnt_clr;
    logic             w_cnt_en;
    logic             w_ticks_clr;
    logic             w_ticks_inc;
    logic             w_tc;
    logic             w_cfg_accept;
    logic [WIDTH-1:0] w_count;

    counter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // Terminal count depends only on registered state, so tick never
    // combinationally follows an input.
    assign w_tc         = (r_state == ST_RUN) && (w_count == r_limit);
    assign w_cfg_accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_limit    <= '0;
            r_periodic <= 1'b0;
            r_ticks    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_cfg_accept) begin
                r_limit    <= cfg_limit;
                r_periodic <= cfg_periodic;
            end
            if (w_ticks_clr) begin
                r_ticks <= '0;
            end else if (w_ticks_inc && (r_ticks != '1)) begin
                r_ticks <= r_ticks + TICKW'(1);
            end
        end
    end

    // Priority within each state: stop, then terminal count, then pause, then start.
    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_ticks_clr  = 1'b0;
        w_ticks_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // The start check uses the limit already held, not one
                // being configured in the same cycle.
                if (start && (r_limit != '0)) begin
                    w_next_state = ST_RUN;
                    w_cnt_clr    = 1'b1;
                    w_ticks_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_cnt_clr    = 1'b1;
                end else if (w_tc) begin
                    w_ticks_inc = 1'b1;
                    if (r_periodic) begin
                        // Wrap to zero; a coincident pause parks at zero.
                        w_cnt_clr    = 1'b1;
                        w_next_state = pause ? ST_PAUSE : ST_RUN;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end else begin
                    // The cycle that sees pause still counts.
                    w_cnt_en = 1'b1;
                    if (pause) begin
                        w_next_state = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_cnt_clr    = 1'b1;
                end else if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_next_state = ST_IDLE;
                    w_cnt_clr    = 1'b1;
                end else if (start) begin
                    w_next_state = ST_RUN;
                    w_cnt_clr    = 1'b1;
                    w_ticks_clr  = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_clr    = 1'b1;
            end
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == ST_IDLE);
        busy      = (r_state == ST_RUN) || (r_state == ST_PAUSE);
        done      = (r_state == ST_DONE);
        tick      = w_tc;
        count     = w_count;
        ticks     = r_ticks;
    end

endmodule
